// File: rtl/bill_change_subtractor.sv
// Bit-serial change calculator: diff = paid - bill, one bit per clock, LSB first.
// Sits downstream of the bill-total adder and feeds the change display/dispense
// logic; the controller sequences it with start and watches busy/done.
module bill_change_subtractor #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] paid,
  input  logic [WIDTH-1:0] bill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] paid_sr;
  logic [WIDTH-1:0] bill_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a;
  logic             b;
  logic             d;
  logic             br_nxt;
  logic             last_bit;

  // One full-subtractor stage on the current LSBs.
  assign a        = paid_sr[0];
  assign b        = bill_sr[0];
  assign d        = a ^ b ^ br;
  assign br_nxt   = (~a & b) | (~(a ^ b) & br);
  assign last_bit = (cnt == LAST_BIT);

  // Status decodes straight from state, so reset clears them asynchronously.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on the accepting edge, one bit per SHIFT edge, publish
  // diff/borrow only on the completing edge so partial results never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paid_sr <= '0;
      bill_sr <= '0;
      res_sr  <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            paid_sr <= paid;
            bill_sr <= bill;
            br      <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          res_sr  <= {d, res_sr[WIDTH-1:1]};
          paid_sr <= paid_sr >> 1;
          bill_sr <= bill_sr >> 1;
          br      <= br_nxt;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            diff   <= {d, res_sr[WIDTH-1:1]};
            borrow <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bill_change_subtractor.sv
// Directed bench for bill_change_subtractor (WIDTH = 13).
module tb_bill_change_subtractor;

  localparam int WIDTH = 13;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] paid;
  logic [WIDTH-1:0] bill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] prev_diff;
  logic             prev_borrow;

  bill_change_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .paid   (paid),
    .bill   (bill),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete subtraction with full latency/hold checking. With disturb set,
  // operands are scrambled and start is pulsed while the DUT is shifting.
  task automatic run_op(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] bl,
                        input bit disturb);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] exp_d;
    logic             exp_b;
    wide  = {1'b0, p} - {1'b0, bl};
    exp_d = wide[WIDTH-1:0];
    exp_b = wide[WIDTH];
    paid  = p;
    bill  = bl;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_at_accept", busy, 1);
    check("done_at_accept", done, 0);
    for (int i = 1; i < WIDTH; i++) begin
      if (disturb) begin
        paid  = WIDTH'($urandom);
        bill  = WIDTH'($urandom);
        start = (i % 3 == 0);
      end
      tick();
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
      check("diff_hold", diff, prev_diff);
      check("borrow_hold", borrow, prev_borrow);
    end
    start = 1'b0;
    tick();
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("diff", diff, exp_d);
    check("borrow", borrow, exp_b);
    prev_diff   = exp_d;
    prev_borrow = exp_b;
    tick();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    if (disturb) begin
      tick();
      tick();
      check("no_extra_done", done, 0);
      check("no_extra_busy", busy, 0);
      check("diff_kept", diff, exp_d);
    end
  endtask

  initial begin
    int last_done;
    int ndone;
    bit seen;

    rst_n       = 1'b0;
    start       = 1'b0;
    paid        = '0;
    bill        = '0;
    prev_diff   = '0;
    prev_borrow = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Main function and boundaries.
    run_op(13'd500,  13'd123,  1'b0);  // 377, no borrow
    run_op(13'd123,  13'd500,  1'b0);  // 7815, borrow
    run_op(13'd4095, 13'd4095, 1'b0);  // equal -> 0, no borrow
    run_op(13'd8191, 13'd0,    1'b0);  // max minus zero
    run_op(13'd0,    13'd1,    1'b0);  // full wrap -> 8191, borrow
    run_op(13'd1000, 13'd1,    1'b1);  // 999 despite mid-shift noise

    // Reset on the 5th SHIFT cycle aborts with all outputs cleared.
    paid  = 13'd321;
    bill  = 13'd21;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    prev_diff   = '0;
    prev_borrow = 1'b0;
    run_op(13'd200, 13'd50, 1'b0);     // 150

    // start held high: one completion every WIDTH+2 cycles.
    paid      = 13'd10;
    bill      = 13'd3;
    start     = 1'b1;
    last_done = -1;
    ndone     = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 15) check("no_accept_in_done", busy, 0);
      if (c == 16) check("reaccept_after_done", busy, 1);
      if (done) begin
        ndone++;
        check("held_diff", diff, 7);
        check("held_borrow", borrow, 0);
        if (last_done >= 0) check("held_period", c - last_done, WIDTH + 2);
        else check("held_first_latency", c, WIDTH + 1);
        last_done = c;
      end
    end
    check("held_done_count", ndone, 2);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("held_final_done", seen, 1);
    check("held_final_diff", diff, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
